// File: rtl/serial_rx_pkg.sv
// rtl/serial_rx_pkg.sv - shared symbols and FSM states for the CPU print-stream receiver
package InstructionStruct;

    localparam logic [6:0] RX_IDLE_CHAR  = 7'h7F;
    localparam logic [6:0] RX_START_CHAR = 7'h00;

    typedef enum logic [1:0] {
        RX_HUNT,
        RX_IDLE,
        RX_FRAME
    } rx_state_t;

endpackage

// File: rtl/serial_rx_fifo.sv
// rtl/serial_rx_fifo.sv - first-word-fall-through character FIFO with drop reporting
module char_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] fill,
    output logic                   drop
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (fill == '0);
    assign full    = (fill == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign drop    = push & ~do_push;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                fill <= fill + 1'b1;
            end else if (!do_push && do_pop) begin
                fill <= fill - 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_rx.sv
// rtl/serial_rx.sv - framing receiver for the CPU tx stream feeding a tagged FWFT FIFO
module serial_rx
    import InstructionStruct::*;
#(
    parameter int DEPTH  = 16,
    parameter int CWIDTH = 7
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [CWIDTH-1:0]      rx_in,
    output logic [CWIDTH-1:0]      rx_data,
    output logic                   rx_last,
    output logic                   rx_valid,
    input  logic                   rx_ready,
    output logic [$clog2(DEPTH):0] fill,
    output logic [15:0]            msg_count,
    output logic                   overflow,
    output logic                   frame_err
);

    localparam logic [CWIDTH-1:0] IDLE_SYM  = CWIDTH'(RX_IDLE_CHAR);
    localparam logic [CWIDTH-1:0] START_SYM = CWIDTH'(RX_START_CHAR);

    rx_state_t         state;
    logic [CWIDTH-1:0] pend;
    logic              pend_v;
    logic              push;
    logic              push_last;
    logic              end_msg;
    logic              fifo_empty;
    logic              fifo_drop;
    logic [CWIDTH:0]   fifo_head;

    // The held character leaves on whatever symbol follows it; a framing symbol marks it last.
    always_comb begin
        push      = 1'b0;
        push_last = 1'b0;
        end_msg   = 1'b0;
        if (state == RX_FRAME && pend_v) begin
            push = 1'b1;
            if (rx_in == IDLE_SYM || rx_in == START_SYM) begin
                push_last = 1'b1;
                end_msg   = 1'b1;
            end
        end
    end

    char_fifo #(
        .WIDTH (CWIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({push_last, pend}),
        .pop       (rx_ready),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .fill      (fill),
        .drop      (fifo_drop)
    );

    assign rx_valid = ~fifo_empty;
    assign rx_data  = fifo_head[CWIDTH-1:0];
    assign rx_last  = fifo_head[CWIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RX_HUNT;
            pend      <= '0;
            pend_v    <= 1'b0;
            msg_count <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (fifo_drop) begin
                overflow <= 1'b1;
            end
            if (end_msg) begin
                msg_count <= msg_count + 16'd1;
            end
            case (state)
                RX_HUNT: begin
                    if (rx_in == IDLE_SYM) begin
                        state <= RX_IDLE;
                    end
                end
                RX_IDLE: begin
                    if (rx_in == START_SYM) begin
                        state  <= RX_FRAME;
                        pend_v <= 1'b0;
                    end else if (rx_in != IDLE_SYM) begin
                        frame_err <= 1'b1;
                        state     <= RX_HUNT;
                    end
                end
                RX_FRAME: begin
                    if (rx_in == IDLE_SYM) begin
                        pend_v <= 1'b0;
                        state  <= RX_IDLE;
                    end else if (rx_in == START_SYM) begin
                        frame_err <= 1'b1;
                        pend_v    <= 1'b0;
                    end else begin
                        pend   <= rx_in;
                        pend_v <= 1'b1;
                    end
                end
                default: state <= RX_HUNT;
            endcase
        end
    end

endmodule
